// File: rtl/bus_cmd_seq_if.sv
// Signal bundle between the bus command sequencer and its surroundings:
// command intake, read responses, and the master port toward the shared bus.
interface bus_cmd_seq_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rw_;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_rw_;
  logic                  breq_;
  logic                  bgrt_;

  modport master (
    input  cmd_valid, cmd_rw_, cmd_addr, cmd_data, bus_rdata, bgrt_,
    output cmd_ready, rsp_valid, rsp_data, bus_addr, bus_wdata, bus_rw_, breq_
  );

  modport slave (
    output cmd_valid, cmd_rw_, cmd_addr, cmd_data, bus_rdata, bgrt_,
    input  cmd_ready, rsp_valid, rsp_data, bus_addr, bus_wdata, bus_rw_, breq_
  );
endinterface

// File: rtl/bus_cmd_seq.sv
// Queued bus-master front end: buffers read/write commands, arbitrates for the
// shared bus with breq_/bgrt_, issues them in order and returns read data.
module bus_cmd_seq #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int HOLD_MAX   = 8
) (
  input  logic          clk,
  input  logic          reset_,
  bus_cmd_seq_if.master bif
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int HOLD_W  = $clog2(HOLD_MAX + 1);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  typedef enum logic [2:0] {IDLE, REQ, ISSUE, CAPTURE, RELEASE} state_t;

  state_t state, state_nxt, cont_state;

  logic [ENTRY_W-1:0]    fifo_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  cmd_ready, push, pop;
  logic                  head_rw_;
  logic [ADDR_WIDTH-1:0] head_addr, cap_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  cap_load, hold_inc, rsp_load;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  breq, bus_rw;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;

  // Ready depends on occupancy only, so a full FIFO refuses even on a pop cycle.
  assign cmd_ready = (count != FULL_CNT);
  assign push      = bif.cmd_valid & cmd_ready;
  assign {head_rw_, head_addr, head_data} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bif.cmd_rw_, bif.cmd_addr, bif.cmd_data};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Where to go after a completed transaction; a same-cycle push keeps the FIFO non-empty.
  always_comb begin
    if ((count == CNT_W'(1)) && !push) cont_state = IDLE;
    else if (hold_cnt + 1'b1 == HOLD_LIM) cont_state = RELEASE;
    else cont_state = ISSUE;
  end

  always_comb begin
    state_nxt = state;
    breq      = 1'b1;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_rw    = 1'b1;
    pop       = 1'b0;
    cap_load  = 1'b0;
    hold_inc  = 1'b0;
    rsp_load  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) state_nxt = REQ;
      end
      REQ: begin
        breq = 1'b0;
        if (!bif.bgrt_) state_nxt = ISSUE;
      end
      ISSUE: begin
        breq      = 1'b0;
        bus_addr  = head_addr;
        bus_rw    = head_rw_;
        bus_wdata = head_rw_ ? '0 : head_data;
        if (bif.bgrt_) begin
          state_nxt = REQ;
        end else if (head_rw_) begin
          cap_load  = 1'b1;
          state_nxt = CAPTURE;
        end else begin
          pop       = 1'b1;
          hold_inc  = 1'b1;
          state_nxt = cont_state;
        end
      end
      CAPTURE: begin
        breq     = 1'b0;
        bus_addr = cap_addr;
        // Losing the grant here leaves the read at the FIFO head so it is replayed.
        if (bif.bgrt_) begin
          state_nxt = REQ;
        end else begin
          rsp_load  = 1'b1;
          pop       = 1'b1;
          hold_inc  = 1'b1;
          state_nxt = cont_state;
        end
      end
      RELEASE: state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE || state_nxt == RELEASE) hold_cnt <= '0;
      else if (hold_inc) hold_cnt <= hold_cnt + 1'b1;
      rsp_valid <= rsp_load;
      if (rsp_load) rsp_data <= bif.bus_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_load) cap_addr <= head_addr;
  end

  assign bif.cmd_ready = cmd_ready;
  assign bif.rsp_valid = rsp_valid;
  assign bif.rsp_data  = rsp_data;
  assign bif.breq_     = breq;
  assign bif.bus_addr  = bus_addr;
  assign bif.bus_wdata = bus_wdata;
  assign bif.bus_rw_   = bus_rw;
endmodule

// File: tb/tb_bus_cmd_seq.sv
// Bench for bus_cmd_seq: plays the shared-bus memory, predicts bus writes and
// read responses from an in-order memory model, and scoreboards them.
module tb_bus_cmd_seq;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int HOLD_MAX = 8;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  bus_cmd_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  bus_cmd_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bif    (bif)
  );

  logic [DW-1:0] bus_mem   [0:(1<<AW)-1];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic deny = 1'b0;
  logic rand_deny = 1'b0;
  bit   rand_mode = 1'b0;

  // The bus grants whenever requested unless the bench is withholding it.
  assign bif.bgrt_     = bif.breq_ | deny | rand_deny;
  assign bif.bus_rdata = bus_mem[bif.bus_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rand_deny = rand_mode && ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #1000000;
    $display("global timeout reached");
    $fatal(1, "bench did not complete");
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr = 0;
  int n_rsp = 0;
  int last_rsp_cyc = 0;
  logic [DW-1:0] last_rsp_data = '0;
  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    exp_rsp[$];
  int wr_cyc[$];
  bit done = 1'b0;
  bit watch = 1'b0;
  int wr_target = 0;
  int breq_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_apply(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (rw) begin
      exp_rsp.push_back(model_mem[a]);
    end else begin
      model_mem[a] = d;
      exp_wr.push_back({a, d});
    end
  endtask

  task automatic send(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit track, output int acc_cyc);
    int g = 0;
    bit acc = 1'b0;
    acc_cyc = 0;
    bif.cmd_valid = 1'b1;
    bif.cmd_rw_   = rw;
    bif.cmd_addr  = a;
    bif.cmd_data  = d;
    while (!acc && g < 300) begin
      @(negedge clk);
      acc = bif.cmd_ready;
      tick();
      g++;
    end
    bif.cmd_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: command to 0x%0h not accepted in %0d cycles", a, g);
    end else begin
      acc_cyc = cyc;
      if (track) model_apply(rw, a, d);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_wr.size() != 0 || exp_rsp.size() != 0 || bif.breq_ !== 1'b1) && g < 3000) begin
      tick();
      g++;
    end
    if (g >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d writes and %0d reads outstanding, required 0",
               exp_wr.size(), exp_rsp.size());
    end
    repeat (2) tick();
  endtask

  task automatic monitor();
    logic [AW+DW-1:0] ew;
    logic [DW-1:0]    er;
    while (!done) begin
      @(negedge clk);
      if (reset_) begin
        if (!bif.bus_rw_ && !bif.bgrt_) begin
          bus_mem[bif.bus_addr] = bif.bus_wdata;
          n_wr++;
          wr_cyc.push_back(cyc);
          if (exp_wr.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write",
                     bif.bus_addr, bif.bus_wdata);
          end else begin
            ew = exp_wr.pop_front();
            check("bus_write", 32'({bif.bus_addr, bif.bus_wdata}), 32'(ew));
          end
        end
        if (bif.rsp_valid) begin
          n_rsp++;
          last_rsp_cyc  = cyc;
          last_rsp_data = bif.rsp_data;
          if (exp_rsp.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: data 0x%0h, required no response", bif.rsp_data);
          end else begin
            er = exp_rsp.pop_front();
            check("rsp_data", 32'(bif.rsp_data), 32'(er));
          end
        end
        if (watch && n_wr < wr_target && bif.breq_) breq_hi++;
      end
    end
  endtask

  task automatic run_tests();
    int ac, r0, w0, base, g;
    // Reset values
    #1;
    check("rst_breq", 32'(bif.breq_), 32'd1);
    check("rst_ready", 32'(bif.cmd_ready), 32'd1);
    check("rst_rw", 32'(bif.bus_rw_), 32'd1);
    check("rst_addr", 32'(bif.bus_addr), 32'd0);
    check("rst_wdata", 32'(bif.bus_wdata), 32'd0);
    check("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bif.rsp_data), 32'd0);
    repeat (2) tick();
    reset_ = 1'b1;
    repeat (2) tick();

    // Single write then read, grant follows request
    send(1'b0, 10'h120, 8'h99, 1'b1, ac);
    g = 0;
    while (n_wr == 0 && g < 50) begin tick(); g++; end
    check("write_latency", 32'(wr_cyc[wr_cyc.size()-1] - ac), 32'd2);
    drain();
    r0 = n_rsp;
    send(1'b1, 10'h120, 8'h00, 1'b1, ac);
    g = 0;
    while (n_rsp == r0 && g < 50) begin tick(); g++; end
    check("read_latency", 32'(last_rsp_cyc - ac), 32'd4);
    check("read_data", 32'(last_rsp_data), 32'h99);
    drain();

    // Burst of queued writes then reads
    deny = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, AW'(10'h090 + i), DW'(8'h50 + i), 1'b1, ac);
    w0 = wr_cyc.size();
    deny = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, AW'(10'h090 + i), 8'h00, 1'b1, ac);
    drain();
    check("burst_wr_count", 32'(wr_cyc.size() - w0), 32'd4);
    if (wr_cyc.size() - w0 == 4) check("burst_consecutive", 32'(wr_cyc[w0+3] - wr_cyc[w0]), 32'd3);

    // Full FIFO with grant withheld
    deny = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, AW'(10'h200 + i), DW'($urandom), 1'b1, ac);
    check("full_ready_low", 32'(bif.cmd_ready), 32'd0);
    bif.cmd_valid = 1'b1;
    bif.cmd_rw_   = 1'b1;
    bif.cmd_addr  = 10'h201;
    repeat (3) tick();
    check("full_ready_held", 32'(bif.cmd_ready), 32'd0);
    deny = 1'b0;
    send(1'b1, 10'h201, 8'h00, 1'b1, ac);
    drain();
    check("ready_after_drain", 32'(bif.cmd_ready), 32'd1);

    // Grant lost during the capture cycle of a read
    r0 = n_rsp;
    send(1'b1, 10'h019, 8'h00, 1'b1, ac);
    repeat (3) tick();
    deny = 1'b1;
    repeat (2) tick();
    check("loss_no_rsp", 32'(n_rsp), 32'(r0));
    check("loss_breq_held", 32'(bif.breq_), 32'd0);
    deny = 1'b0;
    repeat (12) tick();
    check("loss_single_rsp", 32'(n_rsp), 32'(r0 + 1));
    check("loss_rsp_data", 32'(last_rsp_data), 32'hf5);
    drain();

    // Fairness: 12 writes with a tenure limit of 8
    deny = 1'b1;
    base = wr_cyc.size();
    wr_target = n_wr + 12;
    breq_hi = 0;
    for (int i = 0; i < 4; i++) send(1'b0, AW'(10'h300 + i), DW'($urandom), 1'b1, ac);
    deny = 1'b0;
    watch = 1'b1;
    for (int i = 4; i < 12; i++) send(1'b0, AW'(10'h300 + i), DW'($urandom), 1'b1, ac);
    drain();
    watch = 1'b0;
    check("fair_wr_count", 32'(wr_cyc.size() - base), 32'd12);
    check("fair_breq_high", 32'(breq_hi), 32'd1);
    if (wr_cyc.size() - base == 12) begin
      check("fair_first8", 32'(wr_cyc[base+7] - wr_cyc[base]), 32'd7);
      check("fair_gap", 32'(wr_cyc[base+8] - wr_cyc[base+7]), 32'd3);
    end

    // Reset with commands still queued
    deny = 1'b1;
    send(1'b0, 10'h3f0, 8'h11, 1'b0, ac);
    send(1'b1, 10'h3f1, 8'h00, 1'b0, ac);
    send(1'b0, 10'h3f2, 8'h22, 1'b0, ac);
    check("pre_reset_breq", 32'(bif.breq_), 32'd0);
    @(negedge clk);
    #2;
    reset_ = 1'b0;
    #1;
    check("async_rst_breq", 32'(bif.breq_), 32'd1);
    check("async_rst_ready", 32'(bif.cmd_ready), 32'd1);
    check("async_rst_rw", 32'(bif.bus_rw_), 32'd1);
    repeat (2) tick();
    reset_ = 1'b1;
    deny = 1'b0;
    w0 = n_wr;
    r0 = n_rsp;
    repeat (20) tick();
    check("post_rst_no_write", 32'(n_wr), 32'(w0));
    check("post_rst_no_rsp", 32'(n_rsp), 32'(r0));

    // Randomized traffic with random grant withdrawal
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(1'($urandom), AW'(10'h100 + $urandom_range(0, 15)), DW'($urandom), 1'b1, ac);
      if ($urandom_range(0, 2) == 0) tick();
    end
    rand_mode = 1'b0;
    drain();

    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    done = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] v;
    reset_ = 1'b0;
    bif.cmd_valid = 1'b0;
    bif.cmd_rw_   = 1'b1;
    bif.cmd_addr  = '0;
    bif.cmd_data  = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      bus_mem[i]   = v;
      model_mem[i] = v;
    end
    bus_mem[10'h019]   = 8'hf5;
    model_mem[10'h019] = 8'hf5;
    fork
      run_tests();
      monitor();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
